pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/pc_fetch.sv | 118 +++++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// Instruction fetch unit: holds the PC, issues one imem read per instruction,
// registers the returned word for the core and traps on fetch timeout or misaligned next PC.
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc_i,
  output logic [31:0] pc_o,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_o,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic        fault_o,
  output logic [1:0]  fault_code,
  output logic [31:0] fetch_cnt
);

  localparam int unsigned   CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] CODE_NONE     = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT  = 2'b01;
  localparam logic [1:0] CODE_MISALIGN = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_VALID,
    S_FAULT
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [1:0]    code_q, code_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      code_q  <= CODE_NONE;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    code_d  = code_q;
    unique case (state_q)
      S_IDLE: begin
        wait_d  = '0;
        state_d = S_REQ;
      end
      S_REQ: begin
        // An ack on the last allowed cycle still wins over the timeout.
        if (imem_ack) begin
          inst_d  = imem_rdata;
          wait_d  = '0;
          state_d = S_VALID;
        end else if (wait_q == LAST) begin
          code_d  = CODE_TIMEOUT;
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_VALID: begin
        if (inst_ready) begin
          if (npc_i[1:0] == 2'b00) begin
            pc_d    = npc_i;
            cnt_d   = cnt_q + 32'd1;
            wait_d  = '0;
            state_d = S_REQ;
          end else begin
            code_d  = CODE_MISALIGN;
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pc_o       = pc_q;
  assign imem_addr  = pc_q;
  assign imem_req   = (state_q == S_REQ);
  assign inst_o     = inst_q;
  assign inst_valid = (state_q == S_VALID);
  assign fault_o    = (state_q == S_FAULT);
  assign fault_code = code_q;
  assign fetch_cnt  = cnt_q;

endmodule
